// File: rtl/memory_arbiter.sv
// Round-robin arbiter between the instruction-fetch and data ports in front of
// a single strobe/ACK memory port, with a bounded wait per access.
module memory_arbiter #(
  parameter int DATAWIDTH_BUS  = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                     MEMORY_ARBITER_CLOCK_50,
  input  logic                     MEMORY_ARBITER_RESET_InLow,
  input  logic                     MEMORY_ARBITER_IF_REQ_In,
  input  logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_IF_ADDRESS_InBUS,
  output logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_IF_data_OutBUS,
  output logic                     MEMORY_ARBITER_IF_ACK,
  input  logic                     MEMORY_ARBITER_DM_REQ_In,
  input  logic                     MEMORY_ARBITER_DM_WR_In,
  input  logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_DM_ADDRESS_InBUS,
  input  logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_DM_data_InBUS,
  output logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_DM_data_OutBUS,
  output logic                     MEMORY_ARBITER_DM_ACK,
  output logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_MEM_ADDRESS_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_MEM_data_OutBUS,
  output logic                     MEMORY_ARBITER_MEM_RD_Out,
  output logic                     MEMORY_ARBITER_MEM_WR_Out,
  input  logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_MEM_data_InBUS,
  input  logic                     MEMORY_ARBITER_MEM_ACK_In,
  output logic                     MEMORY_ARBITER_BUS_ERROR
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e                   state_q, state_d;
  logic                     last_dm_q, last_dm_d;
  logic                     gnt_dm_q, gnt_dm_d;
  logic                     wr_q, wr_d;
  logic [DATAWIDTH_BUS-1:0] addr_q, addr_d;
  logic [DATAWIDTH_BUS-1:0] wdata_q, wdata_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [DATAWIDTH_BUS-1:0] if_data_q, if_data_d;
  logic [DATAWIDTH_BUS-1:0] dm_data_q, dm_data_d;
  logic                     mem_rd_q, mem_rd_d;
  logic                     mem_wr_q, mem_wr_d;
  logic                     if_ack_q, if_ack_d;
  logic                     dm_ack_q, dm_ack_d;
  logic                     err_q, err_d;
  logic                     grant_dm_s;

  // State and output registers; last-grant pointer resets to DM so IF wins the first tie.
  always_ff @(posedge MEMORY_ARBITER_CLOCK_50 or negedge MEMORY_ARBITER_RESET_InLow) begin
    if (!MEMORY_ARBITER_RESET_InLow) begin
      state_q   <= ST_IDLE;
      last_dm_q <= 1'b1;
      gnt_dm_q  <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= 8'd0;
      if_data_q <= '0;
      dm_data_q <= '0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      if_ack_q  <= 1'b0;
      dm_ack_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_dm_q <= last_dm_d;
      gnt_dm_q  <= gnt_dm_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      if_data_q <= if_data_d;
      dm_data_q <= dm_data_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      if_ack_q  <= if_ack_d;
      dm_ack_q  <= dm_ack_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic; strobes, ACKs and error are computed one edge ahead so they leave registers.
  always_comb begin
    state_d    = state_q;
    last_dm_d  = last_dm_q;
    gnt_dm_d   = gnt_dm_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    if_data_d  = if_data_q;
    dm_data_d  = dm_data_q;
    mem_rd_d   = 1'b0;
    mem_wr_d   = 1'b0;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    err_d      = 1'b0;
    grant_dm_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (MEMORY_ARBITER_IF_REQ_In || MEMORY_ARBITER_DM_REQ_In) begin
          grant_dm_s = MEMORY_ARBITER_DM_REQ_In & (~MEMORY_ARBITER_IF_REQ_In | ~last_dm_q);
          state_d    = ST_ACCESS;
          last_dm_d  = grant_dm_s;
          gnt_dm_d   = grant_dm_s;
          wr_d       = grant_dm_s & MEMORY_ARBITER_DM_WR_In;
          addr_d     = grant_dm_s ? MEMORY_ARBITER_DM_ADDRESS_InBUS : MEMORY_ARBITER_IF_ADDRESS_InBUS;
          wdata_d    = grant_dm_s ? MEMORY_ARBITER_DM_data_InBUS : '0;
          cnt_d      = 8'd0;
          mem_rd_d   = ~(grant_dm_s & MEMORY_ARBITER_DM_WR_In);
          mem_wr_d   = grant_dm_s & MEMORY_ARBITER_DM_WR_In;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // A memory ACK takes priority over a timeout landing on the same edge.
        if (MEMORY_ARBITER_MEM_ACK_In) begin
          state_d  = ST_DONE;
          if_ack_d = ~gnt_dm_q;
          dm_ack_d = gnt_dm_q;
          if (!wr_q) begin
            if (gnt_dm_q) begin
              dm_data_d = MEMORY_ARBITER_MEM_data_InBUS;
            end else begin
              if_data_d = MEMORY_ARBITER_MEM_data_InBUS;
            end
          end else begin
            dm_data_d = dm_data_q;
          end
        end else if (cnt_q == TMO_LAST) begin
          state_d  = ST_DONE;
          if_ack_d = ~gnt_dm_q;
          dm_ack_d = gnt_dm_q;
          err_d    = 1'b1;
          if (gnt_dm_q) begin
            dm_data_d = '0;
          end else begin
            if_data_d = '0;
          end
        end else begin
          cnt_d    = cnt_q + 8'd1;
          mem_rd_d = mem_rd_q;
          mem_wr_d = mem_wr_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign MEMORY_ARBITER_IF_data_OutBUS     = if_data_q;
  assign MEMORY_ARBITER_IF_ACK             = if_ack_q;
  assign MEMORY_ARBITER_DM_data_OutBUS     = dm_data_q;
  assign MEMORY_ARBITER_DM_ACK             = dm_ack_q;
  assign MEMORY_ARBITER_MEM_ADDRESS_OutBUS = addr_q;
  assign MEMORY_ARBITER_MEM_data_OutBUS    = wdata_q;
  assign MEMORY_ARBITER_MEM_RD_Out         = mem_rd_q;
  assign MEMORY_ARBITER_MEM_WR_Out         = mem_wr_q;
  assign MEMORY_ARBITER_BUS_ERROR          = err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: transaction-level model plus per-cycle compare
// and directed scenarios with hand-computed expectations.
module tb_memory_arbiter;
  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        dm_req = 1'b0;
  logic        dm_wr = 1'b0;
  logic [31:0] dm_addr = 32'd0;
  logic [31:0] dm_wdata = 32'd0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;
  logic [31:0] if_data, dm_data, mem_addr, mem_wdata;
  logic        if_ack, dm_ack, mem_rd, mem_wr, bus_err;

  memory_arbiter #(.DATAWIDTH_BUS(32), .TIMEOUT_CYCLES(TMO)) dut (
    .MEMORY_ARBITER_CLOCK_50          (clk),
    .MEMORY_ARBITER_RESET_InLow       (rst_n),
    .MEMORY_ARBITER_IF_REQ_In         (if_req),
    .MEMORY_ARBITER_IF_ADDRESS_InBUS  (if_addr),
    .MEMORY_ARBITER_IF_data_OutBUS    (if_data),
    .MEMORY_ARBITER_IF_ACK            (if_ack),
    .MEMORY_ARBITER_DM_REQ_In         (dm_req),
    .MEMORY_ARBITER_DM_WR_In          (dm_wr),
    .MEMORY_ARBITER_DM_ADDRESS_InBUS  (dm_addr),
    .MEMORY_ARBITER_DM_data_InBUS     (dm_wdata),
    .MEMORY_ARBITER_DM_data_OutBUS    (dm_data),
    .MEMORY_ARBITER_DM_ACK            (dm_ack),
    .MEMORY_ARBITER_MEM_ADDRESS_OutBUS(mem_addr),
    .MEMORY_ARBITER_MEM_data_OutBUS   (mem_wdata),
    .MEMORY_ARBITER_MEM_RD_Out        (mem_rd),
    .MEMORY_ARBITER_MEM_WR_Out        (mem_wr),
    .MEMORY_ARBITER_MEM_data_InBUS    (mem_rdata),
    .MEMORY_ARBITER_MEM_ACK_In        (mem_ack),
    .MEMORY_ARBITER_BUS_ERROR         (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
  } job_t;

  job_t if_jobs[$];
  job_t dm_jobs[$];
  job_t drv_j;
  bit   ack_log[$];

  int checks = 0;
  int errors = 0;
  int ack_dly = 1;
  bit idle_ack = 1'b0;
  bit kill = 1'b0;
  int if_raise_edge = 0, dm_raise_edge = 0, if_ack_edge = 0, dm_ack_edge = 0;
  int err_acks = 0;
  int wr_cycles = 0;

  // model state: one transaction record plus port data registers
  int          edge_n = 0;
  bit          m_active = 1'b0;
  int          m_start = 0, m_end = 0, m_delay = 0, m_n = 0;
  bit          m_dm = 1'b0, m_wr = 1'b0, m_err = 1'b0, m_last_dm = 1'b1, m_g = 1'b0;
  logic [31:0] m_addr = 32'd0, m_wdata = 32'd0, m_if_data = 32'd0, m_dm_data = 32'd0;
  bit          e_rd = 1'b0, e_wr = 1'b0, e_if_ack = 1'b0, e_dm_ack = 1'b0, e_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: an access granted at edge s with ACK delay d completes at edge s+min(d,TMO).
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_active = 1'b0; m_last_dm = 1'b1;
      m_addr = 32'd0; m_wdata = 32'd0; m_if_data = 32'd0; m_dm_data = 32'd0;
      e_rd = 1'b0; e_wr = 1'b0; e_if_ack = 1'b0; e_dm_ack = 1'b0; e_err = 1'b0;
    end else begin
      edge_n = edge_n + 1;
      if (m_active && edge_n == m_end) begin
        if (m_err) begin
          if (m_dm) m_dm_data = 32'd0; else m_if_data = 32'd0;
        end else if (!m_wr) begin
          if (m_dm) m_dm_data = mem_rdata; else m_if_data = mem_rdata;
        end
      end
      if ((!m_active || edge_n >= m_end + 2) && (if_req || dm_req)) begin
        m_g       = dm_req && (!if_req || !m_last_dm);
        m_active  = 1'b1;
        m_start   = edge_n;
        m_dm      = m_g;
        m_wr      = m_g && dm_wr;
        m_addr    = m_g ? dm_addr : if_addr;
        m_wdata   = m_g ? dm_wdata : 32'd0;
        m_last_dm = m_g;
        m_delay   = ack_dly;
        m_n       = (ack_dly >= 1 && ack_dly <= TMO) ? ack_dly : TMO;
        m_err     = (m_n != ack_dly);
        m_end     = edge_n + m_n;
      end
      e_rd     = m_active && edge_n >= m_start && edge_n < m_end && !m_wr;
      e_wr     = m_active && edge_n >= m_start && edge_n < m_end && m_wr;
      e_if_ack = m_active && edge_n == m_end && !m_dm;
      e_dm_ack = m_active && edge_n == m_end && m_dm;
      e_err    = m_active && edge_n == m_end && m_err;
    end
  end

  // memory responder: ACK sampled on edge start+delay
  initial forever begin
    @(negedge clk);
    mem_ack = idle_ack || (rst_n && m_active && m_delay >= 1 && (edge_n + 1 == m_start + m_delay));
  end

  // requesters: raise with next job, drop on the cycle ACK is seen
  initial forever begin
    @(negedge clk);
    if (kill) begin
      if_req = 1'b0; dm_req = 1'b0;
      if_jobs.delete(); dm_jobs.delete();
    end else begin
      if (if_req && if_ack) begin
        if_req = 1'b0;
      end else if (!if_req && if_jobs.size() > 0) begin
        drv_j = if_jobs.pop_front();
        if_addr = drv_j.addr; if_req = 1'b1; if_raise_edge = edge_n;
      end
      if (dm_req && dm_ack) begin
        dm_req = 1'b0;
      end else if (!dm_req && dm_jobs.size() > 0) begin
        drv_j = dm_jobs.pop_front();
        dm_addr = drv_j.addr; dm_wdata = drv_j.wdata; dm_wr = drv_j.wr;
        dm_req = 1'b1; dm_raise_edge = edge_n;
      end
    end
  end

  // per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    chk("mem_rd", 32'(mem_rd), 32'(e_rd));
    chk("mem_wr", 32'(mem_wr), 32'(e_wr));
    chk("if_ack", 32'(if_ack), 32'(e_if_ack));
    chk("dm_ack", 32'(dm_ack), 32'(e_dm_ack));
    chk("bus_err", 32'(bus_err), 32'(e_err));
    chk("if_data", if_data, m_if_data);
    chk("dm_data", dm_data, m_dm_data);
    chk("mem_addr", mem_addr, m_addr);
    if (e_wr) chk("mem_wdata", mem_wdata, m_wdata);
    if (mem_wr) wr_cycles++;
    if (if_ack) begin if_ack_edge = edge_n; ack_log.push_back(1'b0); end
    if (dm_ack) begin dm_ack_edge = edge_n; ack_log.push_back(1'b1); end
    if (bus_err && (if_ack || dm_ack)) err_acks++;
  end

  task automatic push_if(input logic [31:0] a);
    job_t j;
    j.addr = a; j.wdata = 32'd0; j.wr = 1'b0;
    if_jobs.push_back(j);
  endtask

  task automatic push_dm(input logic [31:0] a, input logic [31:0] d, input logic w);
    job_t j;
    j.addr = a; j.wdata = d; j.wr = w;
    dm_jobs.push_back(j);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((if_jobs.size() > 0 || dm_jobs.size() > 0 || if_req || dm_req ||
            (m_active && edge_n < m_end + 2)) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_budget", 32'(k >= budget), 32'd0);
    if (k >= budget) begin
      kill = 1'b1;
      repeat (2) @(negedge clk);
      kill = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  logic [3:0] alt;
  int         n_before;

  initial begin
    // reset held with IF request pending
    ack_dly = 1; mem_rdata = 32'h0000_1111;
    push_if(32'h0000_0100);
    repeat (3) @(negedge clk);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_if_ack", 32'(if_ack), 32'd0);
    chk("rst_dm_ack", 32'(dm_ack), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_mem_rd", 32'(mem_rd), 32'd1);
    chk("rel_mem_addr", mem_addr, 32'h0000_0100);
    wait_idle(50);
    chk("rel_if_data", if_data, 32'h0000_1111);

    // IF read, ACK on first ACCESS cycle
    mem_rdata = 32'h8210_2000;
    push_if(32'h0000_0800);
    wait_idle(50);
    chk("if_latency", if_ack_edge - if_raise_edge, 32'd2);
    chk("if_read_data", if_data, 32'h8210_2000);

    // DM read, then DM write leaves DM data alone
    mem_rdata = 32'h1122_3344;
    push_dm(32'h0000_0904, 32'd0, 1'b0);
    wait_idle(50);
    chk("dm_read_data", dm_data, 32'h1122_3344);
    ack_dly = 2; wr_cycles = 0; mem_rdata = 32'h5555_AAAA;
    push_dm(32'h0000_0900, 32'hDEAD_BEEF, 1'b1);
    wait_idle(50);
    chk("dm_wr_cycles", wr_cycles, 32'd2);
    chk("dm_wr_keeps_data", dm_data, 32'h1122_3344);
    chk("dm_wr_latency", dm_ack_edge - dm_raise_edge, 32'd3);

    // both ports requesting: alternate, IF first after a DM grant
    ack_dly = 1; ack_log.delete(); mem_rdata = 32'h0000_00A5;
    push_if(32'h10); push_if(32'h14);
    push_dm(32'h20, 32'd0, 1'b0); push_dm(32'h24, 32'd0, 1'b0);
    wait_idle(100);
    alt = 4'd0;
    for (int i = 0; i < ack_log.size() && i < 4; i++) alt[i] = ack_log[i];
    chk("alt_count", ack_log.size(), 32'd4);
    chk("alt_order", 32'(alt), 32'h0000_000A);

    // timeout: no ACK for TMO cycles
    ack_dly = 0; mem_rdata = 32'hCAFE_F00D; err_acks = 0;
    push_if(32'h0000_0200);
    wait_idle(100);
    chk("tmo_latency", if_ack_edge - if_raise_edge, 32'd16);
    chk("tmo_if_data", if_data, 32'd0);
    chk("tmo_err_pulses", err_acks, 32'd1);
    ack_dly = 3;
    push_dm(32'h0000_0300, 32'd0, 1'b0);
    wait_idle(50);
    chk("post_tmo_dm_data", dm_data, 32'hCAFE_F00D);
    chk("post_tmo_err", err_acks, 32'd1);

    // ACK on the timeout edge wins
    ack_dly = TMO; mem_rdata = 32'h0BAD_CAFE;
    push_if(32'h0000_0400);
    wait_idle(100);
    chk("edge_latency", if_ack_edge - if_raise_edge, 32'd16);
    chk("edge_if_data", if_data, 32'h0BAD_CAFE);
    chk("edge_err", err_acks, 32'd1);

    // stray MEM_ACK while idle
    n_before = ack_log.size();
    idle_ack = 1'b1;
    repeat (4) @(negedge clk);
    idle_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_ack", ack_log.size(), n_before);

    // reset during ACCESS
    ack_dly = 0;
    push_dm(32'h0000_0500, 32'd0, 1'b0);
    for (int k = 0; k < 20 && !mem_rd; k++) @(negedge clk);
    chk("mid_strobe", 32'(mem_rd), 32'd1);
    @(posedge clk); #1;
    kill = 1'b1; rst_n = 1'b0;
    #1;
    chk("mid_rst_rd", 32'(mem_rd), 32'd0);
    chk("mid_rst_ack", 32'(dm_ack), 32'd0);
    n_before = ack_log.size();
    repeat (3) @(negedge clk);
    kill = 1'b0; rst_n = 1'b1;
    chk("mid_rst_no_ack", ack_log.size(), n_before);
    ack_dly = 2; mem_rdata = 32'h7777_0001; ack_log.delete();
    push_if(32'h0000_0600);
    push_dm(32'h0000_0700, 32'd0, 1'b0);
    wait_idle(100);
    alt = 4'd0;
    for (int i = 0; i < ack_log.size() && i < 2; i++) alt[i] = ack_log[i];
    chk("fresh_count", ack_log.size(), 32'd2);
    chk("fresh_order", 32'(alt), 32'h0000_0002);
    chk("fresh_dm_data", dm_data, 32'h7777_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
